// File: rtl/counter_param_rtl.sv
// counter_param_rtl: loop/address sequencer that counts from a loaded start
// value toward a loaded finish value in steps of a loaded increment, up or
// down, then either stops at finish or wraps back to start. Overshoot is
// clamped so finish is always hit exactly.
//
// Ports:
//   clk      - clock, all state updates on rising edge
//   rst      - synchronous active-low reset
//   load     - capture start/incr/finish/down/wrap and restart (beats en)
//   en       - advance the count by one step
//   start    - start value (captured on load)
//   incr     - unsigned step magnitude (captured on load)
//   finish   - terminal value (captured on load)
//   down     - 0 = count up, 1 = count down (captured on load)
//   wrap     - 0 = stop at finish, 1 = reload start (captured on load)
//   count    - current count (registered)
//   done     - count equals captured finish (decoded from registers)
//   wrapped  - one-cycle pulse, a wrap happened at the previous edge
module counter_param_rtl #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] start,
  input  logic [W-1:0] incr,
  input  logic [W-1:0] finish,
  input  logic         down,
  input  logic         wrap,
  output logic [W-1:0] count,
  output logic         done,
  output logic         wrapped
);

  localparam int unsigned WE = W + 1;

  logic [W-1:0]  start_q;
  logic [W-1:0]  incr_q;
  logic [W-1:0]  finish_q;
  logic          down_q;
  logic          wrap_q;

  logic [WE-1:0] sum;
  logic [W-1:0]  diff;
  logic [W-1:0]  step_val;

  // Next count for one step; any overshoot (including carry-out or borrow)
  // lands exactly on finish, so a direction/finish mismatch also goes
  // straight to finish.
  always_comb begin
    sum      = WE'(count) + WE'(incr_q);
    diff     = count - incr_q;
    step_val = count;
    if (!down_q) begin
      step_val = (sum > WE'(finish_q)) ? finish_q : sum[W-1:0];
    end else begin
      // diff is only meaningful when no borrow occurred
      step_val = ((incr_q > count) || (diff < finish_q)) ? finish_q : diff;
    end
  end

  assign done = (count == finish_q);

  // Configuration, count and wrap-pulse registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      start_q  <= '0;
      incr_q   <= '0;
      finish_q <= '0;
      down_q   <= 1'b0;
      wrap_q   <= 1'b0;
      count    <= '0;
      wrapped  <= 1'b0;
    end else if (load) begin
      start_q  <= start;
      incr_q   <= incr;
      finish_q <= finish;
      down_q   <= down;
      wrap_q   <= wrap;
      count    <= start;
      wrapped  <= 1'b0;
    end else if (en && done) begin
      if (wrap_q) begin
        count   <= start_q;
        wrapped <= 1'b1;
      end else begin
        wrapped <= 1'b0;
      end
    end else if (en) begin
      count   <= step_val;
      wrapped <= 1'b0;
    end else begin
      wrapped <= 1'b0;
    end
  end

endmodule

// File: tb/tb_counter_param_rtl.sv
// Self-checking bench for counter_param_rtl: a 16-bit and an 8-bit instance
// share control inputs and are each tracked by a behavioural model.
module tb_counter_param_rtl;

  logic        clk = 1'b0;
  logic        rst, load, en, down, wrap;
  logic [15:0] s16, i16, f16, c16;
  logic [7:0]  s8, i8, f8, c8;
  logic        d16, w16, d8, w8;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    longint count;
    longint start;
    longint incr;
    longint finish;
    bit     down;
    bit     wrap;
    bit     wrapped;
  } mdl_t;

  mdl_t m16, m8;

  always #5 clk = ~clk;

  counter_param_rtl #(.W(16)) u16 (
    .clk(clk), .rst(rst), .load(load), .en(en),
    .start(s16), .incr(i16), .finish(f16), .down(down), .wrap(wrap),
    .count(c16), .done(d16), .wrapped(w16)
  );

  counter_param_rtl #(.W(8)) u8 (
    .clk(clk), .rst(rst), .load(load), .en(en),
    .start(s8), .incr(i8), .finish(f8), .down(down), .wrap(wrap),
    .count(c8), .done(d8), .wrapped(w8)
  );

  // Reference behaviour: plain integer arithmetic, overshoot clamps to finish
  function automatic mdl_t mdl_next(mdl_t s, bit r, bit ld, bit e,
                                    longint st, longint inc, longint fin,
                                    bit dn, bit wr);
    mdl_t n;
    n = s;
    n.wrapped = 1'b0;
    if (!r) begin
      n.count = 0; n.start = 0; n.incr = 0; n.finish = 0;
      n.down = 1'b0; n.wrap = 1'b0;
    end else if (ld) begin
      n.start = st; n.incr = inc; n.finish = fin;
      n.down = dn; n.wrap = wr; n.count = st;
    end else if (e && s.count == s.finish) begin
      if (s.wrap) begin
        n.count   = s.start;
        n.wrapped = 1'b1;
      end
    end else if (e) begin
      if (!s.down)
        n.count = (s.count + s.incr > s.finish) ? s.finish : s.count + s.incr;
      else
        n.count = (s.count - s.incr < s.finish) ? s.finish : s.count - s.incr;
    end
    return n;
  endfunction

  // One clock: advance both models with the inputs present at the edge
  task automatic tick();
    m16 = mdl_next(m16, rst, load, en, longint'(s16), longint'(i16),
                   longint'(f16), down, wrap);
    m8  = mdl_next(m8, rst, load, en, longint'(s8), longint'(i8),
                   longint'(f8), down, wrap);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; load = 1'b1; en = 1'b1; down = 1'b1; wrap = 1'b1;
    s16 = 16'd77; i16 = 16'd3; f16 = 16'd90; s8 = 8'd7; i8 = 8'd1; f8 = 8'd9;
    tick(); tick();
    n_checks++;
    if (c16 !== 16'd0 || w16 !== 1'b0 || d16 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset16: count=%0d done=%0b wrapped=%0b, expected 0/1/0", c16, d16, w16);
    end
    n_checks++;
    if (c8 !== 8'd0 || w8 !== 1'b0 || d8 !== 1'b1) begin
      n_fail++;
      $display("FAIL reset8: count=%0d done=%0b wrapped=%0b, expected 0/1/0", c8, d8, w8);
    end
    rst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  task automatic test_up_stop();
    int exp_seq[6] = '{3, 5, 7, 9, 9, 9};
    load = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b0;
    s16 = 16'd3; i16 = 16'd2; f16 = 16'd9;
    tick();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (c16 !== 16'(exp_seq[k]) || d16 !== (exp_seq[k] == 9)) begin
        n_fail++;
        $display("FAIL up_stop[%0d]: count=%0d done=%0b, expected %0d/%0b",
                 k, c16, d16, exp_seq[k], exp_seq[k] == 9);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_up_clamp();
    load = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b0;
    s8 = 8'd250; i8 = 8'd10; f8 = 8'd255;
    tick();
    load = 1'b0; en = 1'b1;
    n_checks++;
    if (c8 !== 8'd250 || d8 !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_load: count=%0d done=%0b, expected 250/0", c8, d8);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (c8 !== 8'd255 || d8 !== 1'b1) begin
        n_fail++;
        $display("FAIL clamp_step[%0d]: count=%0d done=%0b, expected 255/1", k, c8, d8);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down_wrap();
    int exp_seq[7] = '{20, 14, 8, 5, 20, 14, 8};
    bit exp_w[7]   = '{0, 0, 0, 0, 1, 0, 0};
    load = 1'b1; en = 1'b0; down = 1'b1; wrap = 1'b1;
    s16 = 16'd20; i16 = 16'd6; f16 = 16'd5;
    tick();
    load = 1'b0; en = 1'b1;
    for (int k = 0; k < 7; k++) begin
      n_checks++;
      if (c16 !== 16'(exp_seq[k]) || w16 !== exp_w[k] || d16 !== (exp_seq[k] == 5)) begin
        n_fail++;
        $display("FAIL down_wrap[%0d]: count=%0d wrapped=%0b done=%0b, expected %0d/%0b/%0b",
                 k, c16, w16, d16, exp_seq[k], exp_w[k], exp_seq[k] == 5);
      end
      tick();
    end
    en = 1'b0;
  endtask

  task automatic test_load_priority();
    int exp_seq[3] = '{100, 101, 102};
    load = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b0;
    s16 = 16'd5; i16 = 16'd2; f16 = 16'd50;
    tick();
    load = 1'b0; en = 1'b1;
    tick();
    n_checks++;
    if (c16 !== 16'd7) begin
      n_fail++;
      $display("FAIL prio_pre: count=%0d, expected 7", c16);
    end
    load = 1'b1; s16 = 16'd100; i16 = 16'd1; f16 = 16'd102;
    tick();
    load = 1'b0;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (c16 !== 16'(exp_seq[k]) || d16 !== (k == 2)) begin
        n_fail++;
        $display("FAIL prio[%0d]: count=%0d done=%0b, expected %0d/%0b",
                 k, c16, d16, exp_seq[k], k == 2);
      end
      if (k < 2) tick();
    end
    en = 1'b0;
  endtask

  task automatic test_en_gate_reset();
    load = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b0;
    s16 = 16'd1; i16 = 16'd2; f16 = 16'd20;
    tick();
    load = 1'b0; en = 1'b1;
    tick(); tick();
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if (c16 !== 16'd5) begin
        n_fail++;
        $display("FAIL en_hold[%0d]: count=%0d, expected 5", k, c16);
      end
    end
    rst = 1'b0; en = 1'b1;
    tick();
    rst = 1'b1; en = 1'b0;
    n_checks++;
    if (c16 !== 16'd0 || d16 !== 1'b1 || w16 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: count=%0d done=%0b wrapped=%0b, expected 0/1/0", c16, d16, w16);
    end
  endtask

  task automatic test_back_to_back_wrap();
    load = 1'b1; en = 1'b0; down = 1'b0; wrap = 1'b1;
    s16 = 16'd42; i16 = 16'd3; f16 = 16'd42;
    tick();
    load = 1'b0; en = 1'b1;
    n_checks++;
    if (c16 !== 16'd42 || d16 !== 1'b1 || w16 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_load: count=%0d done=%0b wrapped=%0b, expected 42/1/0", c16, d16, w16);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      n_checks++;
      if (c16 !== 16'd42 || w16 !== 1'b1) begin
        n_fail++;
        $display("FAIL b2b_wrap[%0d]: count=%0d wrapped=%0b, expected 42/1", k, c16, w16);
      end
    end
    en = 1'b0;
    tick();
    n_checks++;
    if (w16 !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_idle: wrapped=%0b, expected 0", w16);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 600; k++) begin
      rst  = ($urandom_range(0, 59) != 0);
      load = ($urandom_range(0, 11) == 0);
      en   = ($urandom_range(0, 3) != 0);
      down = 1'($urandom);
      wrap = 1'($urandom);
      s16  = 16'($urandom);
      i16  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 2)) : 16'($urandom);
      f16  = 16'($urandom);
      s8   = 8'($urandom);
      i8   = 8'($urandom_range(0, 40));
      f8   = 8'($urandom);
      tick();
      n_checks++;
      if (c16 !== 16'(m16.count) || d16 !== (m16.count == m16.finish) || w16 !== m16.wrapped) begin
        n_fail++;
        $display("FAIL rand16[%0d]: count=%0d done=%0b wrapped=%0b, expected %0d/%0b/%0b",
                 k, c16, d16, w16, m16.count, m16.count == m16.finish, m16.wrapped);
      end
      n_checks++;
      if (c8 !== 8'(m8.count) || d8 !== (m8.count == m8.finish) || w8 !== m8.wrapped) begin
        n_fail++;
        $display("FAIL rand8[%0d]: count=%0d done=%0b wrapped=%0b, expected %0d/%0b/%0b",
                 k, c8, d8, w8, m8.count, m8.count == m8.finish, m8.wrapped);
      end
    end
    rst = 1'b1; load = 1'b0; en = 1'b0;
  endtask

  initial begin
    m16 = '{default: 0};
    m8  = '{default: 0};
    rst = 1'b0; load = 1'b0; en = 1'b0; down = 1'b0; wrap = 1'b0;
    s16 = '0; i16 = '0; f16 = '0; s8 = '0; i8 = '0; f8 = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_up_stop();
    test_up_clamp();
    test_down_wrap();
    test_load_priority();
    test_en_gate_reset();
    test_back_to_back_wrap();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_param_rtl.md
# counter_param_rtl

Parametrised, mode-configurable successor to the 16-bit start/incr/finish counter. It counts from a loaded start value toward a loaded finish value in steps of a loaded increment, up or down. On reaching finish it either stops or wraps back to start. Overshoot is clamped so finish is always hit exactly. It sits beside the datapath as a loop/address sequencer; `done` and `wrapped` feed control FSMs.

## Interface
Parameters:
- `W`, 16, datapath width of count/start/incr/finish (W ≥ 2)

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-low reset (rst==0 at a rising edge resets)
- `load`  in  1  capture configuration and restart; has priority over `en`
- `en`  in  1  advance count by one step this cycle
- `start`  in  W  start value, captured on `load`
- `incr`  in  W  step magnitude (unsigned), captured on `load`
- `finish`  in  W  terminal value, captured on `load`
- `down`  in  1  direction: 0 = count up, 1 = count down; captured on `load`
- `wrap`  in  1  end behaviour: 0 = stop at finish, 1 = reload start; captured on `load`
- `count`  out  W  current count (registered)
- `done`  out  1  count == captured finish (combinational from registers)
- `wrapped`  out  1  one-cycle registered pulse: a wrap occurred at the previous edge

## Operation
- Internal registers: `start_q`, `incr_q`, `finish_q`, `down_q`, `wrap_q`, `count`, `wrapped`.
- Next-state priority, evaluated each rising edge:
  1. `rst`==0: all registers cleared to 0.
  2. `load`==1: capture start/incr/finish/down/wrap; `count` ← `start` (the input, not `start_q`); `wrapped` ← 0.
  3. `en`==1 and `done`==1 and `wrap_q`==1: `count` ← `start_q`; `wrapped` ← 1.
  4. `en`==1 and `done`==1 and `wrap_q`==0: hold; `wrapped` ← 0.
  5. `en`==1 and `done`==0: step (below); `wrapped` ← 0.
  6. Otherwise: hold; `wrapped` ← 0.
- Step arithmetic, computed in W+1 bits:
  - Up: `sum = count + incr_q`. If `sum > finish_q` (including carry-out past 2^W), `count` ← `finish_q`; else `count` ← `sum[W-1:0]`.
  - Down: if `incr_q > count` or `count − incr_q < finish_q`, `count` ← `finish_q`; else `count` ← `count − incr_q`.
  - Clamping ensures `done` is always reached. No modular wrap-around of `count` ever occurs.
- Direction/finish mismatch: if up with `count > finish_q`, or down with `count < finish_q`, a step goes directly to `finish_q`.
- `incr_q`==0 with `done`==0: `count` holds; `done` never asserts (legal, caller's responsibility).
- `start`==`finish` at load: `done`=1 the cycle after load. With `wrap_q`=1 and `en`, `count` stays at start and `wrapped` pulses every cycle.
- `load` mid-count or while done discards progress and restarts immediately.
- Reset mid-operation: cleared on that edge regardless of `load`/`en`.

## Timing
- Reset values: `count`=0, `wrapped`=0, all captured config = 0. Hence `done`=1 out of reset (0==0).
- Load-to-count latency: 1 cycle (`count`==`start` in the cycle after the `load` edge).
- Step latency: 1 cycle per `en`-high edge. No pipelining; one step per cycle sustainable.
- `done` is combinational on `count` and `finish_q`; it is valid in the same cycle `count` reaches finish.
- `wrapped` is high exactly one cycle, coincident with `count`==`start_q` after a wrap. It is back-to-back high if wrapping every cycle.
- `en`/`load`/config inputs are sampled only at rising edges. Outputs never depend combinationally on inputs.

## Test plan
- Reset: hold `rst`=0 two cycles with `load`=1, `en`=1 → `count`=0, `wrapped`=0, `done`=1.
- Up/stop, W=16: load start=3, incr=2, finish=9, down=0, wrap=0; `en`=1 → count 3,5,7,9,9,9; `done` high from the cycle count=9.
- Up clamp/overflow, W=8: load start=250, incr=10, finish=255 → count 250 then 255, `done`=1, never 4.
- Down/wrap: load start=20, incr=6, finish=5, down=1, wrap=1 → count 20,14,8,5,20,14…; `wrapped`=1 only in the cycle count returns to 20.
- Load priority: mid-run at count=7, assert `load`=1 and `en`=1 with start=100, incr=1, finish=102 → next count=100 (not 8); then 101, 102, `done`=1.
- `en` gating and reset mid-run: deassert `en` for 3 cycles at count=5 → count holds at 5. Then `rst`=0 for one cycle with `en`=1 → count=0, `done`=1.
